// File: rtl/debug_pkg.sv
// debug_pkg
// Shared definitions for the register debug path (reg_debug_tap and
// risc_debug_display). Holds the default geometry of the mirrored register
// file and the word/array types both blocks exchange.
//   NREGS     - number of architectural registers mirrored
//   XLEN      - register width in bits
//   RD_W      - width of a register index on the writeback port
//   HL_W      - width of each per-register highlight counter
//   HL_FRAMES - frames a register stays highlighted after its commit
package debug_pkg;

    localparam int NREGS     = 32;
    localparam int XLEN      = 32;
    localparam int RD_W      = 5;
    localparam int HL_W      = 5;
    localparam int HL_FRAMES = 30;

    typedef logic [XLEN-1:0] reg_word_t;
    typedef reg_word_t reg_array_t [0:NREGS-1];

endpackage

// File: rtl/reg_debug_tap_hl_timer.sv
// hl_timer
// Per-register highlight down-counter. A load arms it with HL_FRAMES, each
// decrement (one per committed frame) counts it toward zero, and clear drops
// it to zero immediately, overriding load and decrement.
// Ports:
//   clock   - system clock
//   reset_n - asynchronous active-low reset
//   load    - reload the counter with HL_FRAMES
//   dec     - count down by one if nonzero
//   clear   - force the counter to zero (highest priority)
//   active  - registered (counter != 0)
module hl_timer #(
    parameter int HL_W      = debug_pkg::HL_W,
    parameter int HL_FRAMES = debug_pkg::HL_FRAMES
) (
    input  logic clock,
    input  logic reset_n,
    input  logic load,
    input  logic dec,
    input  logic clear,
    output logic active
);

    localparam logic [HL_W-1:0] LOAD_VAL = HL_W'(HL_FRAMES);

    logic [HL_W-1:0] cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // The highlight output trails the counter by one cycle so it is a clean
    // flop output for the display logic.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            active <= 1'b0;
        end else begin
            active <= (cnt != '0);
        end
    end

endmodule

// File: rtl/reg_debug_tap.sv
// reg_debug_tap
// Snoops the core's register-file writeback port, keeps a live mirror of
// x0..x31 and copies it to a display snapshot once per VGA frame so the
// display never tears. Registers written since the last snapshot are
// highlighted for HL_FRAMES committed frames.
// Ports:
//   clock        - system clock
//   reset_n      - asynchronous active-low reset
//   wb_we        - core register-file write enable
//   wb_rd        - destination register index
//   wb_data      - writeback data
//   frame_start  - VGA vsync-start indicator (rising edge used)
//   freeze       - hold the displayed snapshot while high
//   clear_hl     - single-cycle pulse clearing all highlights
//   regs_demo    - committed display copy of the register file
//   changed_mask - highlight bit per register
//   wr_count     - count of accepted writes, wraps at 2^16
module reg_debug_tap #(
    parameter int NREGS     = debug_pkg::NREGS,
    parameter int XLEN      = debug_pkg::XLEN,
    parameter int HL_FRAMES = debug_pkg::HL_FRAMES,
    parameter int HL_W      = debug_pkg::HL_W
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      wb_we,
    input  logic [debug_pkg::RD_W-1:0] wb_rd,
    input  logic [XLEN-1:0]           wb_data,
    input  logic                      frame_start,
    input  logic                      freeze,
    input  logic                      clear_hl,
    output logic [XLEN-1:0]           regs_demo [0:NREGS-1],
    output logic [NREGS-1:0]          changed_mask,
    output logic [15:0]               wr_count
);

    logic [XLEN-1:0]  live [0:NREGS-1];
    logic [NREGS-1:0] dirty;
    logic [NREGS-1:0] wr_sel;
    logic             wr_accept;
    logic             fs_q;
    logic             fs_q2;
    logic             commit;

    // x0 is hardwired to zero in the core, so writes to it are never mirrored.
    assign wr_accept = wb_we && (wb_rd != '0);
    assign wr_sel    = wr_accept ? (NREGS'(1) << wb_rd) : '0;

    // The commit strobe is decoded from the two-stage frame_start history, so
    // it fires once per rising edge no matter how long frame_start stays high.
    assign commit = fs_q & ~fs_q2 & ~freeze;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fs_q  <= 1'b0;
            fs_q2 <= 1'b0;
        end else begin
            fs_q  <= frame_start;
            fs_q2 <= fs_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                live[i] <= '0;
            end
        end else if (wr_accept) begin
            live[wb_rd] <= wb_data;
        end
    end

    // The snapshot takes the pre-edge mirror, so a write landing in the commit
    // cycle is left for the following frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_demo[i] <= '0;
            end
        end else if (commit) begin
            regs_demo <= live;
        end
    end

    // A write in the commit cycle re-marks its register dirty after the
    // commit has cleared the rest.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dirty <= '0;
        end else begin
            dirty <= (commit ? '0 : dirty) | wr_sel;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_count <= '0;
        end else if (wr_accept) begin
            wr_count <= wr_count + 16'd1;
        end
    end

    // Dirty registers are re-armed on commit; clean ones age by one frame.
    for (genvar i = 0; i < NREGS; i++) begin : g_hl
        hl_timer #(
            .HL_W      (HL_W),
            .HL_FRAMES (HL_FRAMES)
        ) u_hl (
            .clock   (clock),
            .reset_n (reset_n),
            .load    (commit & dirty[i]),
            .dec     (commit & ~dirty[i]),
            .clear   (clear_hl),
            .active  (changed_mask[i])
        );
    end

endmodule

// File: tb/tb_reg_debug_tap.sv
// tb_reg_debug_tap
// Self-checking bench for reg_debug_tap, built with HL_FRAMES=3 so highlight
// ageing is observable in a few frames. A frame-level reference model tracks
// the mirror, snapshot, pending changes, highlight lifetimes and write count.
module tb_reg_debug_tap;

    localparam int NR  = 32;
    localparam int XL  = 32;
    localparam int HLF = 3;
    localparam int HLW = 5;

    logic          clock;
    logic          reset_n;
    logic          wb_we;
    logic [4:0]    wb_rd;
    logic [XL-1:0] wb_data;
    logic          frame_start;
    logic          freeze;
    logic          clear_hl;
    logic [XL-1:0] regs_demo [0:NR-1];
    logic [NR-1:0] changed_mask;
    logic [15:0]   wr_count;

    int compared;
    int mismatched;

    // Reference model state
    logic [XL-1:0] m_live [0:NR-1];
    logic [XL-1:0] m_disp [0:NR-1];
    bit            m_dirty [0:NR-1];
    int            m_hl [0:NR-1];
    logic [NR-1:0] m_mask;
    int            m_cnt;
    bit            m_fs_prev;
    bit            m_pend;

    reg_debug_tap #(
        .NREGS     (NR),
        .XLEN      (XL),
        .HL_FRAMES (HLF),
        .HL_W      (HLW)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .frame_start  (frame_start),
        .freeze       (freeze),
        .clear_hl     (clear_hl),
        .regs_demo    (regs_demo),
        .changed_mask (changed_mask),
        .wr_count     (wr_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_live[i]  = '0;
            m_disp[i]  = '0;
            m_dirty[i] = 1'b0;
            m_hl[i]    = 0;
        end
        m_mask    = '0;
        m_cnt     = 0;
        m_fs_prev = 1'b0;
        m_pend    = 1'b0;
    endtask

    // One clock edge of the reference model: a frame edge seen at one edge
    // commits at the next, unless frozen then.
    task automatic model_edge(input bit we, input logic [4:0] rd, input logic [XL-1:0] data,
                              input bit fs, input bit clr, input bit frz);
        bit do_commit;
        do_commit = m_pend && !frz;
        for (int i = 0; i < NR; i++) begin
            m_mask[i] = (m_hl[i] != 0);
        end
        if (do_commit) begin
            for (int i = 0; i < NR; i++) begin
                m_disp[i] = m_live[i];
                if (m_dirty[i]) begin
                    m_hl[i]    = HLF;
                    m_dirty[i] = 1'b0;
                end else if (m_hl[i] > 0) begin
                    m_hl[i] = m_hl[i] - 1;
                end
            end
        end
        if (clr) begin
            for (int i = 0; i < NR; i++) begin
                m_hl[i] = 0;
            end
        end
        if (we && rd != 5'd0) begin
            m_live[rd]  = data;
            m_dirty[rd] = 1'b1;
            m_cnt       = (m_cnt + 1) % 65536;
        end
        m_pend    = fs && !m_fs_prev;
        m_fs_prev = fs;
    endtask

    task automatic step(input bit we, input logic [4:0] rd, input logic [XL-1:0] data,
                        input bit fs, input bit clr);
        @(negedge clock);
        wb_we       = we;
        wb_rd       = rd;
        wb_data     = data;
        frame_start = fs;
        clear_hl    = clr;
        @(posedge clock);
        model_edge(we, rd, data, fs, clr, freeze);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 5'd0, '0, 1'b0, 1'b0);
    endtask

    task automatic frame_edge();
        step(1'b0, 5'd0, '0, 1'b1, 1'b0);
        repeat (3) idle();
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n     = 1'b0;
        wb_we       = 1'b0;
        wb_rd       = '0;
        wb_data     = '0;
        frame_start = 1'b0;
        freeze      = 1'b0;
        clear_hl    = 1'b0;
        @(posedge clock);
        #1;
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        bit any_nz;
        do_reset();
        idle();
        any_nz = 1'b0;
        for (int i = 0; i < NR; i++) begin
            if (regs_demo[i] !== '0) any_nz = 1'b1;
        end
        compared++;
        if (any_nz !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_regs: some regs_demo entry nonzero, required all zero");
        end
        compared++;
        if (changed_mask !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_mask: got %h required 00000000", changed_mask);
        end
        compared++;
        if (wr_count !== 16'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_count: got %h required 0000", wr_count);
        end
    endtask

    task automatic test_basic_write();
        do_reset();
        step(1'b1, 5'd5, 32'h1234_5678, 1'b0, 1'b0);
        frame_edge();
        compared++;
        if (regs_demo[5] !== 32'h1234_5678) begin
            mismatched++;
            $display("[TB] FAIL basic_x5: got %h required 12345678", regs_demo[5]);
        end
        compared++;
        if (changed_mask !== 32'h0000_0020) begin
            mismatched++;
            $display("[TB] FAIL basic_mask: got %h required 00000020", changed_mask);
        end
        compared++;
        if (wr_count !== 16'd1) begin
            mismatched++;
            $display("[TB] FAIL basic_count: got %0d required 1", wr_count);
        end
    endtask

    task automatic test_x0_ignored();
        do_reset();
        step(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        frame_edge();
        compared++;
        if (regs_demo[0] !== '0) begin
            mismatched++;
            $display("[TB] FAIL x0_value: got %h required 00000000", regs_demo[0]);
        end
        compared++;
        if (changed_mask !== '0) begin
            mismatched++;
            $display("[TB] FAIL x0_mask: got %h required 00000000", changed_mask);
        end
        compared++;
        if (wr_count !== 16'd0) begin
            mismatched++;
            $display("[TB] FAIL x0_count: got %0d required 0", wr_count);
        end
    endtask

    task automatic test_decay();
        bit exp_bit;
        do_reset();
        step(1'b1, 5'd1, 32'hCAFE_0001, 1'b0, 1'b0);
        for (int f = 1; f <= 4; f++) begin
            frame_edge();
            exp_bit = (f <= HLF);
            compared++;
            if (changed_mask[1] !== exp_bit) begin
                mismatched++;
                $display("[TB] FAIL decay_frame%0d: got %b required %b", f, changed_mask[1], exp_bit);
            end
        end
    endtask

    task automatic test_freeze();
        do_reset();
        freeze = 1'b1;
        step(1'b1, 5'd10, 32'hAAAA_BBBB, 1'b0, 1'b0);
        frame_edge();
        frame_edge();
        compared++;
        if (regs_demo[10] !== '0) begin
            mismatched++;
            $display("[TB] FAIL freeze_hold: got %h required 00000000", regs_demo[10]);
        end
        freeze = 1'b0;
        frame_edge();
        compared++;
        if (regs_demo[10] !== 32'hAAAA_BBBB) begin
            mismatched++;
            $display("[TB] FAIL freeze_release: got %h required aaaabbbb", regs_demo[10]);
        end
        compared++;
        if (changed_mask[10] !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL freeze_mask: got %b required 1", changed_mask[10]);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(1'b0, 5'd0, '0, 1'b1, 1'b0);
        // This cycle carries the commit strobe.
        step(1'b1, 5'd7, 32'h0000_0055, 1'b1, 1'b0);
        for (int c = 0; c < 98; c++) begin
            if (c == 20) step(1'b1, 5'd8, 32'h0000_0066, 1'b1, 1'b0);
            else step(1'b0, 5'd0, '0, 1'b1, 1'b0);
        end
        compared++;
        if (regs_demo[7] !== '0 || regs_demo[8] !== '0) begin
            mismatched++;
            $display("[TB] FAIL coincide_hold: got x7=%h x8=%h required 0 and 0", regs_demo[7], regs_demo[8]);
        end
        compared++;
        if (changed_mask !== '0) begin
            mismatched++;
            $display("[TB] FAIL coincide_mask_hold: got %h required 00000000", changed_mask);
        end
        idle();
        idle();
        frame_edge();
        compared++;
        if (regs_demo[7] !== 32'h55 || regs_demo[8] !== 32'h66) begin
            mismatched++;
            $display("[TB] FAIL coincide_next: got x7=%h x8=%h required 55 and 66", regs_demo[7], regs_demo[8]);
        end
        compared++;
        if (changed_mask !== 32'h0000_0180) begin
            mismatched++;
            $display("[TB] FAIL coincide_mask_next: got %h required 00000180", changed_mask);
        end
    endtask

    task automatic test_async_reset();
        bit any_nz;
        do_reset();
        step(1'b1, 5'd3, 32'h0000_DEAD, 1'b0, 1'b0);
        frame_edge();
        compared++;
        if (regs_demo[3] !== 32'h0000_DEAD) begin
            mismatched++;
            $display("[TB] FAIL areset_pre: got %h required 0000dead", regs_demo[3]);
        end
        step(1'b1, 5'd3, 32'h0000_BEEF, 1'b0, 1'b0);
        wb_we = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        compared++;
        if (regs_demo[3] !== '0 || changed_mask !== '0 || wr_count !== 16'd0) begin
            mismatched++;
            $display("[TB] FAIL areset_now: got x3=%h mask=%h count=%h required all zero",
                     regs_demo[3], changed_mask, wr_count);
        end
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        frame_edge();
        any_nz = 1'b0;
        for (int i = 0; i < NR; i++) begin
            if (regs_demo[i] !== '0) any_nz = 1'b1;
        end
        compared++;
        if (any_nz !== 1'b0 || changed_mask !== '0) begin
            mismatched++;
            $display("[TB] FAIL areset_commit: got x3=%h mask=%h required zero snapshot, mask 0",
                     regs_demo[3], changed_mask);
        end
    endtask

    task automatic test_clear_hl();
        do_reset();
        step(1'b1, 5'd2, 32'h0000_0077, 1'b0, 1'b0);
        frame_edge();
        compared++;
        if (changed_mask !== 32'h0000_0004) begin
            mismatched++;
            $display("[TB] FAIL clear_pre_mask: got %h required 00000004", changed_mask);
        end
        step(1'b1, 5'd4, 32'h0000_0099, 1'b0, 1'b0);
        step(1'b0, 5'd0, '0, 1'b1, 1'b0);
        step(1'b0, 5'd0, '0, 1'b0, 1'b1);
        idle();
        idle();
        compared++;
        if (regs_demo[4] !== 32'h0000_0099) begin
            mismatched++;
            $display("[TB] FAIL clear_commit: got %h required 00000099", regs_demo[4]);
        end
        compared++;
        if (changed_mask !== '0) begin
            mismatched++;
            $display("[TB] FAIL clear_mask: got %h required 00000000", changed_mask);
        end
        frame_edge();
        compared++;
        if (changed_mask !== '0) begin
            mismatched++;
            $display("[TB] FAIL clear_dirty_gone: got %h required 00000000", changed_mask);
        end
    endtask

    task automatic test_random();
        bit            fs;
        bit            bad;
        int            bad_idx;
        logic [4:0]    rd;
        logic [XL-1:0] data;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (c % 60 == 0) freeze = ($urandom % 4 == 0);
            fs   = ($urandom % 4 == 0);
            rd   = 5'($urandom);
            data = $urandom;
            step(($urandom % 2) == 1, rd, data, fs, ($urandom % 40) == 0);
            bad     = 1'b0;
            bad_idx = 0;
            for (int i = 0; i < NR; i++) begin
                if (!bad && regs_demo[i] !== m_disp[i]) begin
                    bad     = 1'b1;
                    bad_idx = i;
                end
            end
            compared++;
            if (bad) begin
                mismatched++;
                $display("[TB] FAIL rand_regs cycle %0d x%0d: got %h required %h",
                         c, bad_idx, regs_demo[bad_idx], m_disp[bad_idx]);
            end
            compared++;
            if (changed_mask !== m_mask) begin
                mismatched++;
                $display("[TB] FAIL rand_mask cycle %0d: got %h required %h", c, changed_mask, m_mask);
            end
            compared++;
            if (wr_count !== 16'(m_cnt)) begin
                mismatched++;
                $display("[TB] FAIL rand_count cycle %0d: got %0d required %0d", c, wr_count, m_cnt);
            end
        end
        freeze = 1'b0;
    endtask

    task automatic test_count_wrap();
        do_reset();
        for (int n = 0; n < 65535; n++) begin
            step(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b0, 1'b0);
        end
        compared++;
        if (wr_count !== 16'hFFFF) begin
            mismatched++;
            $display("[TB] FAIL wrap_max: got %h required ffff", wr_count);
        end
        step(1'b1, 5'd9, 32'h1, 1'b0, 1'b0);
        compared++;
        if (wr_count !== 16'(m_cnt) || wr_count !== 16'h0000) begin
            mismatched++;
            $display("[TB] FAIL wrap_zero: got %h required 0000", wr_count);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset_n     = 1'b0;
        wb_we       = 1'b0;
        wb_rd       = '0;
        wb_data     = '0;
        frame_start = 1'b0;
        freeze      = 1'b0;
        clear_hl    = 1'b0;
        model_reset();
        test_reset();
        test_basic_write();
        test_x0_ignored();
        test_decay();
        test_freeze();
        test_back_to_back();
        test_async_reset();
        test_clear_hl();
        test_random();
        test_count_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
